mp_subtract_pipe: RTL and testbench

MP_SUBTRACT_PIPE -- requirements
Module: mp_subtract_pipe

---
 rtl/mp_subtract_pipe.sv | 91 +++++++++
 tb/tb_mp_subtract_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mp_subtract_pipe.sv
// mp_subtract_pipe: two-stage limb-split 1027-bit subtractor with conditional-subtract and valid/ready flow control
module mp_subtract_pipe #(
    parameter int N = 1027,
    parameter int L = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_csub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   result,
    output logic         borrow
);
    localparam int NL  = N / L;
    localparam int TOP = (NL - 1) * L;

    logic [N:0]    c_d0, s1_d0;
    logic [N-L:0]  c_d1, s1_d1;
    logic [NL-2:0] c_bo0, s1_bo0;
    logic [NL-2:1] c_bo1, s1_bo1;
    logic          s1_valid, s1_csub;
    logic [N-1:0]  s1_a;
    logic          s2_free;
    logic [NL-1:1] br;
    logic [N:0]    diff;

    assign s2_free  = !out_valid | out_ready;
    assign in_ready = !rst & (!s1_valid | s2_free);

    // Per-limb difference candidates for borrow-in 0 and 1; the top limb is one bit wider to carry the sign
    always_comb begin
        c_d0  = '0;
        c_d1  = '0;
        c_bo0 = '0;
        c_bo1 = '0;
        for (int i = 0; i < NL - 1; i++)
            {c_bo0[i], c_d0[i*L +: L]} = {1'b0, in_a[i*L +: L]} - {1'b0, in_b[i*L +: L]};
        for (int i = 1; i < NL - 1; i++)
            {c_bo1[i], c_d1[(i-1)*L +: L]} = {1'b0, in_a[i*L +: L]} - {1'b0, in_b[i*L +: L]} - (L+1)'(1);
        c_d0[N:TOP]     = {1'b0, in_a[N-1:TOP]} - {1'b0, in_b[N-1:TOP]};
        c_d1[N-L:TOP-L] = {1'b0, in_a[N-1:TOP]} - {1'b0, in_b[N-1:TOP]} - (N-TOP+1)'(1);
    end

    // Ripple the registered limb borrows and pick each limb's candidate
    always_comb begin
        br              = '0;
        diff            = '0;
        diff[L-1:0]     = s1_d0[L-1:0];
        br[1]           = s1_bo0[0];
        for (int i = 1; i < NL - 1; i++) begin
            diff[i*L +: L] = br[i] ? s1_d1[(i-1)*L +: L] : s1_d0[i*L +: L];
            br[i+1]        = br[i] ? s1_bo1[i] : s1_bo0[i];
        end
        diff[N:TOP] = br[NL-1] ? s1_d1[N-L:TOP-L] : s1_d0[N:TOP];
    end

    // Stage 1: capture candidates, mode and minuend of an accepted beat
    always_ff @(posedge clk) begin
        if (rst)
            s1_valid <= 1'b0;
        else if (in_ready)
            s1_valid <= in_valid;
        if (in_valid && in_ready) begin
            s1_d0   <= c_d0;
            s1_d1   <= c_d1;
            s1_bo0  <= c_bo0;
            s1_bo1  <= c_bo1;
            s1_csub <= in_csub;
            s1_a    <= in_a;
        end
    end

    // Stage 2: resolved result, held until the downstream takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            borrow    <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= (s1_csub && diff[N]) ? {1'b0, s1_a} : diff;
                borrow <= diff[N];
            end
        end
    end
endmodule

// File: tb/tb_mp_subtract_pipe.sv
// tb_mp_subtract_pipe: randomized and directed checks of mp_subtract_pipe against an arithmetic reference queue
module tb_mp_subtract_pipe;
    localparam int N = 1027;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic         in_csub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N:0]   result;
    logic         borrow;

    int           tests = 0;
    int           fails = 0;
    logic [N+1:0] q[$];
    logic         stall_prev = 1'b0;
    logic [N:0]   res_prev = '0;
    logic         accepted;

    mp_subtract_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_csub(in_csub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .borrow(borrow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N:0] got, input logic [N:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h..%h exp=%h..%h", tag, got[N:N-63], got[127:0], exp[N:N-63], exp[127:0]);
        end
    endtask

    // Reference: full-width subtraction, borrow as a magnitude compare, csub restores the minuend
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        logic       lt;
        logic [N:0] d;
        lt = a < b;
        d  = {1'b0, a} - {1'b0, b};
        return {lt, (c && lt) ? {1'b0, a} : d};
    endfunction

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < 33; i++) v = (v << 32) | N'($urandom);
        return v;
    endfunction

    // One cycle: account for the handshakes the coming edge performs, then move to the next falling edge
    task automatic tick();
        logic [N+1:0] e;
        #1;
        accepted = 1'b0;
        if (stall_prev) begin
            chk("hold_valid", (N+1)'(out_valid), (N+1)'(1));
            chk("hold_result", result, res_prev);
        end
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", (N+1)'(1), (N+1)'(0));
                else begin
                    e = q.pop_front();
                    chk("result", result, e[N:0]);
                    chk("borrow", (N+1)'(borrow), (N+1)'(e[N+1]));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b, in_csub));
                accepted = 1'b1;
            end
            stall_prev = out_valid && !out_ready;
            res_prev   = result;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_csub = c;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (accepted) begin
                in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", (N+1)'(1), (N+1)'(0));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 200 && q.size() != 0; k++) tick();
        tick();
        tick();
        chk("drain_empty", (N+1)'(q.size()), (N+1)'(0));
    endtask

    task automatic latency_beat(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        out_ready = 1'b1;
        send(a, b, c);
        chk("lat_cycle1_valid", (N+1)'(out_valid), (N+1)'(0));
        tick();
        chk("lat_cycle2_valid", (N+1)'(out_valid), (N+1)'(1));
        drain();
    endtask

    logic [N-1:0] ba[4];
    logic [N-1:0] bb[4];
    int           idx;
    int           sent;
    int           m;
    logic [N-1:0] a, b;

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", (N+1)'(out_valid), (N+1)'(0));
        chk("rst_result", result, (N+1)'(0));
        chk("rst_borrow", (N+1)'(borrow), (N+1)'(0));
        chk("rst_in_ready", (N+1)'(in_ready), (N+1)'(0));
        rst = 1'b0;
        #1;
        chk("ready_after_rst", (N+1)'(in_ready), (N+1)'(1));
        @(negedge clk);

        a = N'({129{8'h5A}});
        latency_beat(a, a, 1'b0);
        latency_beat('0, '1, 1'b0);
        latency_beat(N'(1) << 64, N'(1), 1'b0);
        latency_beat(N'(100), N'(200), 1'b1);
        latency_beat(N'(200), N'(100), 1'b1);
        latency_beat('1, '0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            ba[i] = rnd();
            bb[i] = rnd();
        end
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = idx < 4;
            in_a = ba[idx % 4];
            in_b = bb[idx % 4];
            in_csub = idx[0];
            tick();
            if (accepted) idx++;
        end
        chk("bp_accepts", (N+1)'(idx), (N+1)'(2));
        chk("bp_in_ready", (N+1)'(in_ready), (N+1)'(0));
        chk("bp_out_valid", (N+1)'(out_valid), (N+1)'(1));
        out_ready = 1'b1;
        for (int c = 0; c < 50 && idx < 4; c++) begin
            in_valid = 1'b1;
            in_a = ba[idx];
            in_b = bb[idx];
            in_csub = idx[0];
            tick();
            if (accepted) idx++;
        end
        chk("bp_all_sent", (N+1)'(idx), (N+1)'(4));
        drain();

        out_ready = 1'b0;
        send(rnd(), rnd(), 1'b0);
        send(rnd(), rnd(), 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", (N+1)'(out_valid), (N+1)'(0));
        chk("midrst_result", result, (N+1)'(0));
        latency_beat(N'(12345), N'(54321), 1'b0);

        sent = 0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            m = $urandom_range(0, 3);
            a = rnd();
            b = rnd();
            if (m == 1) b = a;
            if (m == 2) b = a ^ (N'(1) << $urandom_range(0, 200));
            if (m == 3) b[N-1:960] = a[N-1:960];
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 9) < 7;
            in_a = a;
            in_b = b;
            in_csub = $urandom_range(0, 1) != 0;
            tick();
            if (accepted) sent++;
        end
        chk("random_sent", (N+1)'(sent), (N+1)'(10000));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
